// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// mainmem read/write pin levels and the byte-lane merge used by sub-word stores.
package mem_arb_pkg;

    // FSM state encoding, kept as plain constants for legacy tools
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE   = 2'd0;
    localparam arb_state_t ST_ACCESS = 2'd1;
    localparam arb_state_t ST_RMW_RD = 2'd2;
    localparam arb_state_t ST_RMW_WR = 2'd3;

    // mainmem read_write pin levels
    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    // Word width the merge helper operates on (one byte enable per lane)
    localparam int PKG_DATA_W = 32;
    localparam int PKG_BE_W   = PKG_DATA_W / 8;

    // Per byte lane: take the new byte where enabled, else keep the old one
    function automatic logic [PKG_DATA_W-1:0] be_merge(
        input logic [PKG_DATA_W-1:0] old_word,
        input logic [PKG_DATA_W-1:0] new_word,
        input logic [PKG_BE_W-1:0]   be
    );
        logic [PKG_DATA_W-1:0] merged;
        merged = '0;
        for (int i = 0; i < PKG_BE_W; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end else begin
                merged[i*8 +: 8] = old_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Priority decision between fetch and data requesters. Data normally wins;
// a fetch that has lost MAX_WAIT data grants in a row is forced through.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic clock,
    input  logic reset_n,
    input  logic idle,
    input  logic if_req,
    input  logic d_req,
    output logic grant_if,
    output logic grant_d
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    logic [CNT_W-1:0] starve_cnt;
    logic             fetch_forced;

    // Combinational grant: one winner at most, and only while idle
    always_comb begin
        fetch_forced = if_req && (starve_cnt == MAX_CNT);
        grant_d      = 1'b0;
        grant_if     = 1'b0;
        if (idle) begin
            grant_d  = d_req && !fetch_forced;
            grant_if = if_req && !grant_d;
        end else begin
            grant_d  = 1'b0;
            grant_if = 1'b0;
        end
    end

    // Count data grants taken while a fetch waits; a fetch grant clears it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_d && if_req && (starve_cnt != MAX_CNT)) begin
            starve_cnt <= starve_cnt + ONE_CNT;
        end else begin
            starve_cnt <= starve_cnt;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single mainmem port between instruction fetch (read-only) and the
// load/store unit. Accesses are serialised through a small FSM; sub-word stores
// become a read followed by a merged write.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_data_in,
    input  logic [DATA_W-1:0]   mem_data_out,
    output logic                mem_read_write
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [BE_W-1:0]   BE_ALL    = '1;
    localparam logic [BE_W-1:0]   BE_NONE   = '0;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

    arb_state_t        state;
    logic              cap_we;
    logic              cap_owner_if;
    logic [DATA_W-1:0] cap_wdata;
    logic [BE_W-1:0]   cap_be;
    logic [DATA_W-1:0] merge_q;
    logic              grant_if;
    logic              grant_d;

    mem_arb_pick #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .clock    (clock),
        .reset_n  (reset_n),
        .idle     (state == ST_IDLE),
        .if_req   (if_req),
        .d_req    (d_req),
        .grant_if (grant_if),
        .grant_d  (grant_d)
    );

    assign if_gnt = grant_if;
    assign d_gnt  = grant_d;

    // Sequencer: capture the winner, run the access, return data and rvalid
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cap_we       <= 1'b0;
            cap_owner_if <= 1'b0;
            cap_wdata    <= '0;
            cap_be       <= '0;
            merge_q      <= '0;
            mem_address  <= '0;
            if_rvalid    <= 1'b0;
            if_rdata     <= '0;
            d_rvalid     <= 1'b0;
            d_rdata      <= '0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_d) begin
                        cap_we       <= d_we;
                        cap_owner_if <= 1'b0;
                        cap_wdata    <= d_wdata;
                        cap_be       <= d_be;
                        mem_address  <= d_addr & WORD_MASK;
                        // Only genuine sub-word stores need the read-modify-write
                        if (d_we && (d_be != BE_ALL) && (d_be != BE_NONE)) begin
                            state <= ST_RMW_RD;
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end else if (grant_if) begin
                        cap_we       <= 1'b0;
                        cap_owner_if <= 1'b1;
                        cap_wdata    <= '0;
                        cap_be       <= '0;
                        mem_address  <= if_addr & WORD_MASK;
                        state        <= ST_ACCESS;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    state <= ST_IDLE;
                    if (cap_owner_if) begin
                        if_rdata  <= mem_data_out;
                        if_rvalid <= 1'b1;
                    end else begin
                        d_rvalid <= 1'b1;
                        if (cap_we) begin
                            d_rdata <= '0;
                        end else begin
                            d_rdata <= mem_data_out;
                        end
                    end
                end
                ST_RMW_RD: begin
                    merge_q <= mem_data_out;
                    state   <= ST_RMW_WR;
                end
                ST_RMW_WR: begin
                    d_rdata  <= '0;
                    d_rvalid <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory pin drive decoded from the state register, so reset drops WRITE at once
    always_comb begin
        mem_read_write = READ;
        mem_data_in    = '0;
        case (state)
            ST_ACCESS: begin
                if (cap_we && (cap_be == BE_ALL)) begin
                    mem_read_write = WRITE;
                    mem_data_in    = cap_wdata;
                end else begin
                    mem_read_write = READ;
                    mem_data_in    = '0;
                end
            end
            ST_RMW_WR: begin
                mem_read_write = WRITE;
                mem_data_in    = be_merge(merge_q, cap_wdata, cap_be);
            end
            default: begin
                mem_read_write = READ;
                mem_data_in    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small mainmem model (combinational
// read, write on the rising edge while read_write is WRITE).
module tb_mem_arbiter;

    logic        clock;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_read_write;

    logic [31:0] mem [64];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;

    int checks;
    int errors;

    mem_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (4)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_gnt         (if_gnt),
        .if_rvalid      (if_rvalid),
        .if_rdata       (if_rdata),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_be           (d_be),
        .d_gnt          (d_gnt),
        .d_rvalid       (d_rvalid),
        .d_rdata        (d_rdata),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .mem_read_write (mem_read_write)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // mainmem model: preload port for the bench, write port for the DUT
    always @(posedge clock) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (mem_read_write) begin
            mem[mem_address[7:2]] <= mem_data_in;
        end
    end

    assign mem_data_out = mem[mem_address[7:2]];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        if_req  = 1'b0;
        if_addr = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        d_be    = 4'h0;
        pl_en   = 1'b0;
        pl_idx  = 6'd0;
        pl_data = 32'h0;

        // Reset state
        #12;
        check("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        check("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_mem_data_in", mem_data_in, 32'h0);
        check("rst_mem_rw", {31'd0, mem_read_write}, 32'd0);

        // Preload mainmem words at 0x01000000 and 0x01000020
        pl_en   = 1'b1;
        pl_idx  = 6'd0;
        pl_data = 32'hCAFEF00D;
        step();
        pl_idx  = 6'd8;
        pl_data = 32'h11223344;
        step();
        pl_en   = 1'b0;
        #3;
        reset_n = 1'b1;
        step();

        // Single fetch
        if_req  = 1'b1;
        if_addr = 32'h01000000;
        #1;
        check("fetch_if_gnt", {31'd0, if_gnt}, 32'd1);
        check("fetch_d_gnt", {31'd0, d_gnt}, 32'd0);
        step();
        if_req = 1'b0;
        check("fetch_addr", mem_address, 32'h01000000);
        check("fetch_rw", {31'd0, mem_read_write}, 32'd0);
        step();
        check("fetch_rvalid", {31'd0, if_rvalid}, 32'd1);
        check("fetch_rdata", if_rdata, 32'hCAFEF00D);
        step();
        check("fetch_rvalid_pulse", {31'd0, if_rvalid}, 32'd0);

        // Full store then load (misaligned load address lands on the same word)
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h01000010;
        d_wdata = 32'hDEADBEEF;
        d_be    = 4'hF;
        #1;
        check("st_gnt", {31'd0, d_gnt}, 32'd1);
        step();
        d_req = 1'b0;
        check("st_rw", {31'd0, mem_read_write}, 32'd1);
        check("st_addr", mem_address, 32'h01000010);
        check("st_data_in", mem_data_in, 32'hDEADBEEF);
        step();
        check("st_rvalid", {31'd0, d_rvalid}, 32'd1);
        check("st_rdata", d_rdata, 32'h0);
        check("st_idle_rw", {31'd0, mem_read_write}, 32'd0);
        check("st_idle_data_in", mem_data_in, 32'h0);
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h01000012;
        #1;
        check("ld_gnt_with_rvalid", {31'd0, d_gnt}, 32'd1);
        step();
        d_req = 1'b0;
        check("ld_addr_aligned", mem_address, 32'h01000010);
        check("ld_rw", {31'd0, mem_read_write}, 32'd0);
        step();
        check("ld_rvalid", {31'd0, d_rvalid}, 32'd1);
        check("ld_rdata", d_rdata, 32'hDEADBEEF);
        step();

        // Partial store (read-modify-write)
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h01000020;
        d_wdata = 32'h0000AA00;
        d_be    = 4'b0010;
        #1;
        check("rmw_gnt", {31'd0, d_gnt}, 32'd1);
        step();
        d_req = 1'b0;
        check("rmw_rd_rw", {31'd0, mem_read_write}, 32'd0);
        check("rmw_rd_addr", mem_address, 32'h01000020);
        step();
        check("rmw_wr_rw", {31'd0, mem_read_write}, 32'd1);
        check("rmw_wr_data", mem_data_in, 32'h1122AA44);
        check("rmw_no_early_rvalid", {31'd0, d_rvalid}, 32'd0);
        step();
        check("rmw_rvalid", {31'd0, d_rvalid}, 32'd1);
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h01000020;
        step();
        d_req = 1'b0;
        step();
        check("rmw_readback", d_rdata, 32'h1122AA44);
        step();

        // Store with no byte enables: no WRITE cycle, memory untouched
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h01000000;
        d_wdata = 32'hFFFFFFFF;
        d_be    = 4'h0;
        #1;
        check("be0_gnt", {31'd0, d_gnt}, 32'd1);
        step();
        d_req = 1'b0;
        check("be0_no_write", {31'd0, mem_read_write}, 32'd0);
        step();
        check("be0_rvalid", {31'd0, d_rvalid}, 32'd1);
        if_req  = 1'b1;
        if_addr = 32'h01000000;
        step();
        if_req = 1'b0;
        step();
        check("be0_mem_unchanged", if_rdata, 32'hCAFEF00D);
        step();

        // Contention: both requests held, expect D D D D F D D D D F
        if_req  = 1'b1;
        if_addr = 32'h01000000;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h01000020;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("cont_d_gnt", {31'd0, d_gnt}, (i % 5 == 4) ? 32'd0 : 32'd1);
            check("cont_if_gnt", {31'd0, if_gnt}, (i % 5 == 4) ? 32'd1 : 32'd0);
            step();
            step();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        step();

        // Reset during the WRITE cycle of a read-modify-write
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h01000020;
        d_wdata = 32'h77000000;
        d_be    = 4'b1000;
        step();
        d_req = 1'b0;
        step();
        check("rst_rmw_in_write", {31'd0, mem_read_write}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_rmw_rw_drop", {31'd0, mem_read_write}, 32'd0);
        check("rst_rmw_addr", mem_address, 32'h0);
        step();
        check("rst_rmw_no_rvalid", {31'd0, d_rvalid}, 32'd0);
        #3;
        reset_n = 1'b1;
        step();
        check("rst_rmw_no_rvalid_after", {31'd0, d_rvalid}, 32'd0);
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h01000020;
        #1;
        check("post_rst_gnt", {31'd0, d_gnt}, 32'd1);
        step();
        d_req = 1'b0;
        step();
        check("post_rst_rvalid", {31'd0, d_rvalid}, 32'd1);
        check("post_rst_mem_unchanged", d_rdata, 32'h1122AA44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
